// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule. Emits round keys 0..NR one per accepted transfer;
// each key is computed from the currently presented one, so no key store is needed.

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  logic [127:0] row;
  logic [3:0]   col_inv;

  always_comb begin
    row = 128'h0;
    case (in_i[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
      default: row = 128'h0;
    endcase
  end

  // Column 0 sits in the top byte of each row.
  assign col_inv = ~in_i[3:0];
  assign out_o   = row[{col_inv, 3'b000} +: 8];
endmodule

module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done
);
  // Handshake: a round key moves on a rising edge where rk_valid & rk_ready; while
  // rk_valid is high and rk_ready low, rk_out and rk_round hold for any length of time.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] rk_next;
  logic [7:0]   rcon_xt;
  logic         last_round;

  assign {w0, w1, w2, w3} = rk_q;
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot_w[8*i +: 8]),
      .out_o (sub_w[8*i +: 8])
    );
  end

  assign t_w     = sub_w ^ {rcon_q, 24'h0};
  assign n0      = w0 ^ t_w;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  assign rcon_xt    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  assign last_round = (round_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rk_q    <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          rk_d    = key_in;
          round_d = 4'd0;
          rcon_d  = 8'h01;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (last_round) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rk_d    = rk_next;
            round_d = round_q + 4'd1;
            // 8'h36 feeds the final key; it is never stepped further.
            if (rcon_q != 8'h36) rcon_d = rcon_xt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == RUN);
    rk_valid = (state_q == RUN);
    rk_round = round_q;
    rk_out   = rk_q;
    done     = done_q;
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key-expansion vectors,
// including backpressure, start on busy/done edges and reset mid-expansion.

module tb_aes_key_expand;
  logic         clk = 1'b0;
  logic         rst_n, start, rk_ready;
  logic [127:0] key_in;
  logic         busy, rk_valid, done;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [127:0] exp_q[$];
  bit           chk_q[$];

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_R2  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
  localparam logic [127:0] C1_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] A1_TAB [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  always #5 clk = ~clk;

  aes_key_expand #(.NR(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .done     (done)
  );

  task automatic load_a1();
    exp_q.delete(); chk_q.delete();
    for (int i = 0; i <= 10; i++) begin exp_q.push_back(A1_TAB[i]); chk_q.push_back(1'b1); end
  endtask

  task automatic load_c1();
    exp_q.delete(); chk_q.delete();
    exp_q.push_back(KEY_C1); chk_q.push_back(1'b1);
    exp_q.push_back(C1_R1);  chk_q.push_back(1'b1);
    exp_q.push_back(C1_R2);  chk_q.push_back(1'b1);
    for (int i = 3; i <= 9; i++) begin exp_q.push_back('0); chk_q.push_back(1'b0); end
    exp_q.push_back(C1_R10); chk_q.push_back(1'b1);
  endtask

  // Runs one expansion from IDLE and returns on the cycle where done should be high.
  task automatic run_expansion(input logic [127:0] key, input bit rand_ready,
                               input int poke_round, input string tag);
    int cyc, idx;
    bit rdy, stalled, poked;
    logic [127:0] held;
    @(negedge clk);
    key_in = key; start = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; key_in = ~key;
    cyc = 1; idx = 0; stalled = 1'b0; poked = 1'b0; held = '0;
    while (idx <= 10 && cyc < 400) begin
      n_cmp++;
      if (rk_valid !== 1'b1 || busy !== 1'b1) begin
        n_fail++; $display("FAIL %s valid_busy: got %b%b want 11", tag, rk_valid, busy);
      end
      n_cmp++;
      if (rk_round !== 4'(idx)) begin
        n_fail++; $display("FAIL %s rk_round: got %0d want %0d", tag, rk_round, idx);
      end
      if (chk_q[0]) begin
        n_cmp++;
        if (rk_out !== exp_q[0]) begin
          n_fail++; $display("FAIL %s rk_out r%0d: got %h want %h", tag, idx, rk_out, exp_q[0]);
        end
      end else if (stalled) begin
        n_cmp++;
        if (rk_out !== held) begin
          n_fail++; $display("FAIL %s hold r%0d: got %h want %h", tag, idx, rk_out, held);
        end
      end
      if (idx == poke_round && !poked) begin
        start = 1'b1; key_in = KEY_C1 ^ key; poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      rk_ready = rdy;
      held = rk_out;
      @(negedge clk);
      cyc++;
      if (rdy) begin
        idx++; stalled = 1'b0;
        void'(exp_q.pop_front()); void'(chk_q.pop_front());
      end else begin
        stalled = 1'b1;
      end
    end
    start = 1'b0;
    rk_ready = 1'b0;
    if (idx <= 10) begin
      n_cmp++; n_fail++;
      $display("FAIL %s timeout: got %0d keys want 11", tag, idx);
    end else begin
      n_cmp++;
      if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL %s done_cycle: got d=%b v=%b b=%b want 1 0 0", tag, done, rk_valid, busy);
      end
      if (!rand_ready) begin
        n_cmp++;
        if (cyc != 12) begin
          n_fail++; $display("FAIL %s latency: got %0d want 12", tag, cyc);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got b=%b v=%b d=%b want 0 0 0", busy, rk_valid, done);
    end
    n_cmp++;
    if (rk_round !== 4'd0 || rk_out !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got r=%0d k=%h want 0 0", rk_round, rk_out);
    end
    rst_n = 1'b1; rk_ready = 1'b1; key_in = KEY_A1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_round !== 4'd0) begin
      n_fail++; $display("FAIL idle_ready: got v=%b b=%b r=%0d want 0 0 0", rk_valid, busy, rk_round);
    end
    rk_ready = 1'b0;
  endtask

  task automatic check_done_drops(input string tag);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s done_width: got d=%b v=%b want 0 0", tag, done, rk_valid);
    end
  endtask

  task automatic test_fips_c1();
    load_c1(); run_expansion(KEY_C1, 1'b0, -1, "c1"); check_done_drops("c1");
  endtask

  task automatic test_fips_a1();
    load_a1(); run_expansion(KEY_A1, 1'b0, -1, "a1"); check_done_drops("a1");
  endtask

  task automatic test_backpressure();
    load_a1(); run_expansion(KEY_A1, 1'b1, -1, "bp_a1"); check_done_drops("bp_a1");
    load_c1(); run_expansion(KEY_C1, 1'b1, -1, "bp_c1"); check_done_drops("bp_c1");
  endtask

  task automatic test_start_while_busy();
    load_a1(); run_expansion(KEY_A1, 1'b0, 4, "busy_start"); check_done_drops("busy_start");
  endtask

  task automatic test_start_in_done();
    int n_xfer, budget;
    logic [3:0]   last_r;
    logic [127:0] last_k;
    load_c1(); run_expansion(KEY_C1, 1'b0, -1, "pre_done");
    start = 1'b1; key_in = KEY_A1;
    @(negedge clk);
    start = 1'b0; key_in = '0;
    n_cmp++;
    if (done !== 1'b0 || rk_valid !== 1'b1 || busy !== 1'b1 || rk_round !== 4'd0 || rk_out !== KEY_A1) begin
      n_fail++; $display("FAIL done_restart: got d=%b v=%b b=%b r=%0d k=%h want 0 1 1 0 %h",
                         done, rk_valid, busy, rk_round, rk_out, KEY_A1);
    end
    rk_ready = 1'b1; n_xfer = 0; budget = 0; last_r = '0; last_k = '0;
    while (rk_valid === 1'b1 && budget < 40) begin
      last_r = rk_round; last_k = rk_out; n_xfer++; budget++;
      @(negedge clk);
    end
    rk_ready = 1'b0;
    n_cmp++;
    if (n_xfer != 11 || last_r !== 4'd10 || last_k !== A1_TAB[10] || done !== 1'b1) begin
      n_fail++; $display("FAIL done_restart_drain: got n=%0d r=%0d k=%h d=%b want 11 10 %h 1",
                         n_xfer, last_r, last_k, done, A1_TAB[10]);
    end
    check_done_drops("done_restart");
  endtask

  task automatic test_reset_mid_run();
    int budget;
    @(negedge clk);
    start = 1'b1; key_in = KEY_A1; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    budget = 0;
    while (rk_round !== 4'd6 && budget < 20) begin
      budget++; @(negedge clk);
    end
    n_cmp++;
    if (rk_round !== 4'd6 || rk_out !== A1_TAB[6]) begin
      n_fail++; $display("FAIL mid_reach_r6: got r=%0d k=%h want 6 %h", rk_round, rk_out, A1_TAB[6]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk_round !== 4'd0) begin
      n_fail++; $display("FAIL mid_reset: got v=%b b=%b d=%b r=%0d want 0 0 0 0", rk_valid, busy, done, rk_round);
    end
    rst_n = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_no_done: got d=%b v=%b want 0 0", done, rk_valid);
    end
    load_c1(); run_expansion(KEY_C1, 1'b0, -1, "after_reset"); check_done_drops("after_reset");
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_fips_a1();
    test_backpressure();
    test_start_while_busy();
    test_start_in_done();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule that sits directly upstream of one_round and supplies its key_in.
- Accepts a 128-bit cipher key on a start pulse, then produces round keys 0..10, one per accepted transfer, over a valid/ready stream.
- Each round key is derived from the previously emitted one in a single cycle, so no 11-entry key store is needed.
- Uses four instances of the team's existing combinational byte S-box.

Parameters:
- NR, 10, index of the last round key; only 10 is legal (AES-128).

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  one-cycle request to begin an expansion; samples key_in
- key_in  input  128  cipher key, FIPS-197 byte order (MSB = byte 0)
- busy  output  1  high from the cycle after start is accepted until done
- rk_valid  output  1  rk_out and rk_round are valid
- rk_ready  input  1  downstream accepts the current round key
- rk_round  output  4  index of the round key on rk_out, 0..10
- rk_out  output  128  current round key
- done  output  1  one-cycle pulse after round key 10 is accepted

Behaviour:
- Synchronous reset (rst_n=0 at a clk edge):
  - busy, rk_valid, done = 0; rk_round = 0; rk_out = 0; rcon = 8'h01; FSM = IDLE.
  - A reset mid-expansion aborts the expansion immediately. No done pulse is generated.
- FSM states: IDLE and RUN.
- IDLE:
  - start=1 at an edge gives, next cycle: FSM=RUN, busy=1, rk_valid=1, rk_round=0, rk_out=key_in, rcon=8'h01.
  - start=0 keeps the block in IDLE.
- RUN, transfer = rk_valid & rk_ready at a clk edge:
  - No transfer: rk_out, rk_round and rk_valid hold stable. The hold is unbounded and the output must not glitch.
  - Transfer with rk_round < NR: next cycle rk_out = g(rk_out, rcon), rk_round+1, rk_valid stays 1, and rcon = xtime(rcon).
  - xtime sequence: 01,02,04,08,10,20,40,80,1b,36.
  - Transfer with rk_round = NR: next cycle rk_valid=0, busy=0, done=1, FSM=IDLE.
  - done lasts exactly one cycle.
- Round function g(w0..w3), with w0 = bits [127:96]:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0' = w0 ^ t
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - The path is purely combinational from registered rk_out and rcon to the rk_out D input.
- Throughput: with rk_ready held at 1, rk_valid is high for exactly 11 consecutive cycles (rounds 0..10), with no bubbles.
- Latency: start to first rk_valid is 1 cycle. start to done is 12 cycles with rk_ready=1.
- start while busy=1 is ignored. key_in is not re-sampled.
- start in the same cycle as the done pulse (FSM already IDLE) is accepted normally.
- rk_ready while rk_valid=0 has no effect.
- rk_round never exceeds NR. rcon is never advanced past 8'h36.

Test Plan:
- Reset, start with key_in=000102030405060708090a0b0c0d0e0f, rk_ready=1:
  - Round 0 = 000102030405060708090a0b0c0d0e0f.
  - Round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
  - Round 2 = b692cf0b643dbdf1be9bc5006830b3fe.
  - Round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - done arrives 12 cycles after start.
- key_in=2b7e151628aed2a6abf7158809cf4f3c:
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Checks all 10 rcon values via the full FIPS-197 Appendix A.1 table.
- Backpressure: toggle rk_ready pseudo-randomly.
  - rk_out and rk_round hold while not ready.
  - The same 11 keys appear in order, each accepted exactly once.
- Start on IDLE and busy edges:
  - Pulse start with a different key at round 4: the sequence continues unchanged.
  - Start in the done cycle: a new expansion begins with rk_round=0.
- Reset mid-run: drive rst_n=0 at round 6.
  - Next cycle rk_valid=0, busy=0, done=0.
  - A subsequent start yields round 0 correctly.
- Chain with one_round: feed rk_round=1 output plus state 00102030405060708090a0b0c0d0e0f0.
  - one_round state_out = 89d810e8855ace682d1843d8cb128fe4.
